// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-file geometry,
// default latencies, opcode constants and the flush FSM encoding.
package pipe_hazard_ctrl_pkg;

  localparam int REGNOBITS    = 4;
  localparam int NREGS        = 1 << REGNOBITS;
  localparam int WB_LAT_DEF   = 2;
  localparam int CNTBITS_DEF  = 32;

  localparam logic [5:0] OP1_SPECIAL = 6'o00;
  localparam logic [5:0] OP1_JAL     = 6'o03;
  localparam logic [5:0] OP1_BEQ     = 6'o04;
  localparam logic [5:0] OP1_BNE     = 6'o05;
  localparam logic [5:0] OP1_ADDI    = 6'o10;
  localparam logic [5:0] OP1_LW      = 6'o43;
  localparam logic [5:0] OP1_SW      = 6'o53;

  localparam logic [5:0] OP2_ADD     = 6'o40;
  localparam logic [5:0] OP2_SUB     = 6'o42;
  localparam logic [5:0] OP2_AND     = 6'o44;
  localparam logic [5:0] OP2_OR      = 6'o45;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

  typedef logic [1:0] pend_t;

  function automatic pend_t pend_dec(input pend_t p);
    return (p == '0) ? p : p - 2'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Per-register pending-write down-counters: two read ports for the ID sources,
// one load port for the issuing destination, global decrement every cycle.
module hz_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WB_LAT = WB_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [REGNOBITS-1:0] rd_a,
  input  logic [REGNOBITS-1:0] rd_b,
  input  logic                 set_en,
  input  logic [REGNOBITS-1:0] set_reg,
  output logic                 busy_a,
  output logic                 busy_b
);

  pend_t pend_q [NREGS];
  pend_t pend_d [NREGS];

  // A load on the same entry wins over its decrement.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      pend_d[r] = pend_dec(pend_q[r]);
      if (set_en && (set_reg == REGNOBITS'(r))) begin
        pend_d[r] = pend_t'(WB_LAT);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r] <= pend_d[r];
      end
    end
  end

  always_comb begin
    busy_a = (pend_q[rd_a] != '0);
    busy_b = (pend_q[rd_b] != '0);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: RAW stall detection via the scoreboard, mispredict flush FSM,
// output gating after reset and saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WB_LAT  = WB_LAT_DEF,
  parameter int CNTBITS = CNTBITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_id,
  input  logic [REGNOBITS-1:0] rs_id,
  input  logic [REGNOBITS-1:0] rt_id,
  input  logic                 use_rs_id,
  input  logic                 use_rt_id,
  input  logic                 wr_reg_id,
  input  logic [REGNOBITS-1:0] wregno_id,
  input  logic                 mispred_ex,
  output logic                 stall,
  output logic                 flush_id,
  output logic                 issue_id,
  output logic [CNTBITS-1:0]   stall_cnt,
  output logic [CNTBITS-1:0]   flush_cnt
);

  logic               run_q, run_d;
  flush_state_e       state_q, state_d;
  logic               flush_raw;
  logic               busy_rs, busy_rt, hazard;
  logic [CNTBITS-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNTBITS-1:0] flush_cnt_q, flush_cnt_d;

  hz_scoreboard #(.WB_LAT(WB_LAT)) u_sb (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_a    (rs_id),
    .rd_b    (rt_id),
    .set_en  (issue_id & wr_reg_id),
    .set_reg (wregno_id),
    .busy_a  (busy_rs),
    .busy_b  (busy_rt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      run_q       <= run_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // A mispredict seen in FLUSH restarts the two-cycle kill window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = mispred_ex ? FLUSH : RUN;
      FLUSH:   state_d = mispred_ex ? FLUSH : RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    flush_raw = 1'b0;
    case (state_q)
      RUN:     flush_raw = mispred_ex;
      FLUSH:   flush_raw = 1'b1;
      default: flush_raw = 1'b0;
    endcase
  end

  always_comb begin
    run_d    = 1'b1;
    hazard   = valid_id & ((use_rs_id & busy_rs) | (use_rt_id & busy_rt));
    flush_id = run_q & flush_raw;
    stall    = run_q & hazard & ~flush_id;
    issue_id = run_q & valid_id & ~hazard & ~flush_id;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNTBITS'(1);
    end
    if (flush_id && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNTBITS'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
